// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall counter.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WE_W   = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  input  logic [WE_W-1:0]   in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo,
  output logic [WE_W-1:0]   out_we,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = ADDR_W + 3 * DATA_W + WE_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     main_reg, main_next;
  logic [PW-1:0]     skid_reg, skid_next;
  logic [PW-1:0]     in_payload;
  logic [WE_W-1:0]   held_we;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              out_valid_int;
  logic              in_ready_int;
  logic              accept;
  logic              consume;

  assign in_payload = {in_waddr, in_wdata, in_hi, in_lo, in_we};
  assign accept     = in_valid && in_ready_int;
  assign consume    = out_valid_int && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // Flush wins over everything; stale data may stay in main/skid.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_next  = in_payload;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_next = in_payload;
          end else if (accept && SKID != 0) begin
            skid_next  = in_payload;
            state_next = TWO;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            main_next  = skid_reg;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // With the skid buffer, in_ready depends only on registered state and reset.
  always_comb begin
    out_valid_int = (state_reg != EMPTY);
    if (SKID != 0) begin
      in_ready_int = rst && (state_reg != TWO);
    end else begin
      in_ready_int = rst && (!out_valid_int || out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (out_valid_int && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign {out_waddr, out_wdata, out_hi, out_lo, held_we} = main_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WE_W; gi++) begin : g_we_gate
      assign out_we[gi] = held_we[gi] & out_valid_int;
    end
  endgenerate

  assign out_valid = out_valid_int;
  assign in_ready  = in_ready_int;
  assign stall_cnt = stall_cnt_reg;

endmodule
